mvau_weight_seq: RTL and testbench
==================================

MVAU_WEIGHT_SEQ -- requirements
Module: mvau_weight_seq

Interface
REQ-001 The block SHALL have parameter SIMD, default 2, input lanes per weight word.
REQ-002 The block SHALL have parameter TW, default 1, bits per weight.
REQ-003 The block SHALL have parameter SF, default 2, synapse fold (words per neuron group).
REQ-004 The block SHALL have parameter NF, default 2, neuron fold (neuron groups per image).
REQ-005 The block SHALL have parameter WMEM_ADDR_BW, default 4, weight memory address width, with SF*NF <= 2**WMEM_ADDR_BW.
REQ-006 The block SHALL have parameter REP_BW, default 16, width of the repetition count.
REQ-007 The block SHALL have port aclk, input, 1, single clock; all logic on its rising edge.
REQ-008 The block SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1, pulse that launches a run.
REQ-010 The block SHALL have port num_reps, input, REP_BW, images per run, sampled with start.
REQ-011 The block SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-012 The block SHALL have port done, output, 1, one-cycle end-of-run pulse.
REQ-013 The block SHALL have port wmem_addr, output, WMEM_ADDR_BW, read address to the weight memory.
REQ-014 The block SHALL have port wmem_in, input, SIMD*TW, weight memory read data, valid one cycle after wmem_addr.
REQ-015 The block SHALL have port wgt_data, output, SIMD*TW, weight word to the MVAU datapath.
REQ-016 The block SHALL have ports wgt_valid (output, 1) and wgt_ready (input, 1), AXI-Stream-style handshake.
REQ-017 The block SHALL have ports wgt_sf_last and wgt_nf_last, outputs, 1 each, tags on wgt_data for last sf and last nf.

Function
REQ-018 The block SHALL implement states IDLE, RUN and DRAIN; start is accepted only in IDLE and ignored otherwise.
REQ-019 On accepting start with num_reps>0, the block SHALL go to RUN; with num_reps=0 it SHALL stay in IDLE, issue no reads and pulse done in the next cycle.
REQ-020 In RUN, reads SHALL be issued in the order sf inner, nf outer, rep outermost, with wmem_addr = nf*SF + sf wrapping to 0 after SF*NF-1.
REQ-021 The block SHALL buffer read data in a 2-entry FIFO and issue a read only when (occupancy + in-flight - pop) < 2, so no word is lost under backpressure.
REQ-022 wmem_addr SHALL only advance when a read is issued; it SHALL hold otherwise.
REQ-023 With wgt_ready held high, the block SHALL sustain one word per cycle; the first wgt_valid SHALL occur 3 cycles after the start cycle.
REQ-024 wgt_data, wgt_sf_last and wgt_nf_last SHALL remain stable while wgt_valid=1 and wgt_ready=0.
REQ-025 wgt_sf_last SHALL be 1 for sf=SF-1; wgt_nf_last SHALL be 1 only for sf=SF-1 and nf=NF-1.
REQ-026 After the final read is issued, the block SHALL enter DRAIN; after the final handshake it SHALL pulse done, drop busy and return to IDLE in the same cycle.
REQ-027 The sf, nf and rep counters SHALL be sized from SF, NF and REP_BW without overflow; the supported maximum is num_reps = 2**REP_BW-1.

Reset
REQ-028 On aresetn low, the block SHALL asynchronously enter IDLE, clear the counters and FIFO, and drive busy=0, done=0, wgt_valid=0, wmem_addr=0, wgt_data=0 and both tag outputs to 0.
REQ-029 When reset is asserted during a run, the block SHALL abandon the run with no done pulse; after release it SHALL wait for a new start.

Configuration
REQ-030 With macro MVAU_WSEQ_STALL_CNT_EN defined, the block SHALL add output stall_cnt[31:0], which counts cycles with wgt_valid=1 and wgt_ready=0, is cleared on accepted start and on reset, and saturates at all-ones; without the macro, the port and its logic SHALL be absent.

Verification
REQ-031 With SF=2, NF=2, num_reps=1 and ready always high, the bench SHALL check addresses 0,1,2,3 on consecutive cycles, first wgt_valid at start+3, sf_last on words 2 and 4, nf_last on word 4 only, and done one cycle after word 4.
REQ-032 With num_reps=3 and ready toggling 1/0 every cycle, the bench SHALL check 12 words in address sequence 0-3 repeated, no loss or duplication, and stable data during stalls.
REQ-033 With ready held low for 10 cycles mid-run, the bench SHALL check that wmem_addr is frozen, at most 2 words are buffered, output resumes in order and stall_cnt=10 when the macro is defined.
REQ-034 With num_reps=0, the bench SHALL check that done pulses at start+1, wgt_valid never rises and busy stays 0.
REQ-035 With aresetn pulsed low after word 2 of a run, the bench SHALL check that all outputs are 0 immediately, there is no done pulse, and a fresh start restarts at address 0.
REQ-036 With start asserted while busy, the bench SHALL check that the run is unaffected and the word count equals the original num_reps*SF*NF.

Source files
------------

// File: rtl/mvau_weight_seq.sv
// Weight-stream sequencer for an MVAU: walks weight memory (sf inner, nf outer, rep outermost)
// through a 2-entry skid FIFO. Optional stall counter port enabled by MVAU_WSEQ_STALL_CNT_EN.
module mvau_weight_seq #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned SF           = 2,
    parameter int unsigned NF           = 2,
    parameter int unsigned WMEM_ADDR_BW = 4,
    parameter int unsigned REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [REP_BW-1:0]       num_reps,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    output logic [SIMD*TW-1:0]      wgt_data,
    output logic                    wgt_valid,
    input  logic                    wgt_ready,
    output logic                    wgt_sf_last,
    output logic                    wgt_nf_last
`ifdef MVAU_WSEQ_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int unsigned DW   = SIMD * TW;
    localparam int unsigned SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned NF_W = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_W-1:0]         SF_LAST   = SF_W'(SF - 1);
    localparam logic [NF_W-1:0]         NF_LAST   = NF_W'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(SF * NF - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [SF_W-1:0]         sf_q, sf_d;
    logic [NF_W-1:0]         nf_q, nf_d;
    logic [REP_BW-1:0]       rep_q, rep_d;
    logic [REP_BW-1:0]       reps_q, reps_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic                    done_q, done_d;

    // Read issued last cycle; its data and tags land in the FIFO this cycle.
    logic                    rd_q, rd_sfl_q, rd_nfl_q;

    logic [DW-1:0]           fifo_data_q [2];
    logic [1:0]              fifo_sfl_q, fifo_nfl_q;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              occ_q;

    logic                    start_acc, issue, pop, fin_pop;
    logic                    tag_sfl, tag_nfl, last_rd;
    logic [2:0]              level;

    always_comb begin
        start_acc = (state_q == IDLE) && start;
        pop       = (occ_q != 2'd0) && wgt_ready;
        level     = 3'(occ_q) + 3'(rd_q) - 3'(pop);
        tag_sfl   = (sf_q == SF_LAST);
        tag_nfl   = tag_sfl && (nf_q == NF_LAST);
        last_rd   = tag_nfl && (rep_q == reps_q - REP_BW'(1));
        fin_pop   = pop && (occ_q == 2'd1) && !rd_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (num_reps != '0)) state_d = RUN;
            RUN:     if (issue && last_rd)           state_d = DRAIN;
            DRAIN:   if (fin_pop)                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        issue       = (state_q == RUN) && (level < 3'd2);
        wgt_valid   = (occ_q != 2'd0);
        wgt_data    = wgt_valid ? fifo_data_q[rd_ptr_q] : '0;
        wgt_sf_last = wgt_valid && fifo_sfl_q[rd_ptr_q];
        wgt_nf_last = wgt_valid && fifo_nfl_q[rd_ptr_q];
        wmem_addr   = addr_q;
        done        = done_q;
        done_d      = (start_acc && (num_reps == '0)) || ((state_q == DRAIN) && fin_pop);
    end

    always_comb begin
        sf_d   = sf_q;
        nf_d   = nf_q;
        rep_d  = rep_q;
        reps_d = reps_q;
        addr_d = addr_q;
        if (start_acc) begin
            sf_d   = '0;
            nf_d   = '0;
            rep_d  = '0;
            addr_d = '0;
            reps_d = num_reps;
        end else if (issue) begin
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + WMEM_ADDR_BW'(1);
            if (tag_sfl) begin
                sf_d = '0;
                if (nf_q == NF_LAST) begin
                    nf_d  = '0;
                    rep_d = rep_q + REP_BW'(1);
                end else begin
                    nf_d = nf_q + NF_W'(1);
                end
            end else begin
                sf_d = sf_q + SF_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sf_q           <= '0;
            nf_q           <= '0;
            rep_q          <= '0;
            reps_q         <= '0;
            addr_q         <= '0;
            done_q         <= 1'b0;
            rd_q           <= 1'b0;
            rd_sfl_q       <= 1'b0;
            rd_nfl_q       <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_sfl_q     <= '0;
            fifo_nfl_q     <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            occ_q          <= '0;
        end else begin
            sf_q     <= sf_d;
            nf_q     <= nf_d;
            rep_q    <= rep_d;
            reps_q   <= reps_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            rd_q     <= issue;
            rd_sfl_q <= issue && tag_sfl;
            rd_nfl_q <= issue && tag_nfl;
            // Issue gating keeps occupancy + in-flight <= 2, so a push never meets a full FIFO.
            if (rd_q) begin
                fifo_data_q[wr_ptr_q] <= wmem_in;
                fifo_sfl_q[wr_ptr_q]  <= rd_sfl_q;
                fifo_nfl_q[wr_ptr_q]  <= rd_nfl_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + 2'(rd_q) - 2'(pop);
        end
    end

`ifdef MVAU_WSEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                           stall_cnt_q <= '0;
        else if (start_acc)                                     stall_cnt_q <= '0;
        else if (wgt_valid && !wgt_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mvau_weight_seq.sv
// Self-checking bench for mvau_weight_seq: table-driven runs, hand-written corner sequences
// and randomized backpressure, all checked against a queue of expected words.
module tb_mvau_weight_seq;

    localparam int SF  = 2;
    localparam int NF  = 2;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int RBW = 16;

    logic           aclk      = 1'b0;
    logic           aresetn   = 1'b0;
    logic           start     = 1'b0;
    logic [RBW-1:0] num_reps  = '0;
    logic           wgt_ready = 1'b0;
    logic           busy, done, wgt_valid, wgt_sf_last, wgt_nf_last;
    logic [AW-1:0]  wmem_addr;
    logic [DW-1:0]  wmem_in, wgt_data;
`ifdef MVAU_WSEQ_STALL_CNT_EN
    logic [31:0]    stall_cnt;
`endif

    mvau_weight_seq #(
        .SIMD(4), .TW(2), .SF(SF), .NF(NF), .WMEM_ADDR_BW(AW), .REP_BW(RBW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .num_reps(num_reps),
        .busy(busy), .done(done), .wmem_addr(wmem_addr), .wmem_in(wmem_in),
        .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .wgt_sf_last(wgt_sf_last), .wgt_nf_last(wgt_nf_last)
`ifdef MVAU_WSEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    // Synchronous-read weight memory: data valid one cycle after the address.
    logic [DW-1:0] mem [16];
    always @(posedge aclk) wmem_in <= mem[wmem_addr];

    int cyc_n = 0;
    always @(posedge aclk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          n;
    } word_t;

    word_t exp_q[$];
    word_t mon_w, prev_w;
    logic  prev_stall = 1'b0;

    int n_checks = 0, n_fail = 0;
    int word_cnt = 0, done_cnt = 0, done_cyc = -1, last_word_cyc = -1, first_valid_cyc = -1;
    int start_cyc, busy_seen, words0, done0, stall_left, addr_chg, addr3;
    int addr_log [8];

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_eq(input string name, input longint act, input longint exp);
        chk(name, act == exp, act, exp);
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("stall_valid_held", longint'(wgt_valid), 1);
                chk("stall_word_stable",
                    (wgt_data == prev_w.d) && (wgt_sf_last == prev_w.s) && (wgt_nf_last == prev_w.n),
                    longint'(wgt_data), longint'(prev_w.d));
            end
            if (wgt_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
            if (wgt_valid && wgt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1'b0, longint'(wgt_data), -1);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk_eq("word_data", longint'(wgt_data), longint'(mon_w.d));
                    chk_eq("word_sf_last", longint'(wgt_sf_last), longint'(mon_w.s));
                    chk_eq("word_nf_last", longint'(wgt_nf_last), longint'(mon_w.n));
                end
                word_cnt++;
                last_word_cyc = cyc_n;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            prev_stall = wgt_valid && !wgt_ready;
            prev_w     = '{wgt_data, wgt_sf_last, wgt_nf_last};
        end
    end

    // Reference ordering: rep outermost, nf, then sf innermost.
    task automatic build_exp(input int reps);
        word_t w;
        for (int r = 0; r < reps; r++)
            for (int nf = 0; nf < NF; nf++)
                for (int sf = 0; sf < SF; sf++) begin
                    w.d = mem[nf * SF + sf];
                    w.s = (sf == SF - 1);
                    w.n = (sf == SF - 1) && (nf == NF - 1);
                    exp_q.push_back(w);
                end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0: wgt_ready = 1'b1;
            1: wgt_ready = ~wgt_ready;
            2: wgt_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if ((word_cnt - words0 >= 2) && (stall_left > 0)) begin
                    wgt_ready = 1'b0;
                    stall_left--;
                end else begin
                    wgt_ready = 1'b1;
                end
            end
        endcase
    endtask

    task automatic do_run(input int reps, input int mode, input bit restart);
        bit            finished;
        int            stall_idx;
        logic [AW-1:0] prev_addr;
        build_exp(reps);
        words0 = word_cnt; done0 = done_cnt; busy_seen = 0;
        stall_left = 10; addr_chg = 0; addr3 = -1; stall_idx = 0; prev_addr = '0;
        tick();
        start = 1'b1; num_reps = RBW'(reps); start_cyc = cyc_n; first_valid_cyc = -1;
        set_ready(mode);
        @(negedge aclk); #1;
        finished = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            start = restart && (i == 3);
            if (start) num_reps = RBW'(5);
            set_ready(mode);
            @(negedge aclk); #1;
            if (i < 8) addr_log[i] = int'(wmem_addr);
            if (busy) busy_seen = 1;
            if (mode == 3 && !wgt_ready) begin
                stall_idx++;
                if (stall_idx > 1 && wmem_addr != prev_addr) addr_chg++;
                prev_addr = wmem_addr;
                if (stall_idx == 3) addr3 = int'(wmem_addr);
                if (stall_idx == 10) chk_eq("addr_frozen_in_stall", longint'(wmem_addr), longint'(addr3));
            end
            if (done_cnt != done0) begin
                finished = 1'b1;
                break;
            end
        end
        chk_eq("run_completes", longint'(finished), 1);
        start = 1'b0;
        repeat (6) begin
            tick();
            wgt_ready = 1'b1;
            @(negedge aclk); #1;
        end
        chk_eq("single_done", done_cnt - done0, 1);
        chk_eq("queue_drained", exp_q.size(), 0);
        chk_eq("busy_low_after", longint'(busy), 0);
    endtask

    typedef struct {
        int reps;
        int mode;
        int exp_words;
        int exp_first;
        int exp_done;
        int exp_busy;
        bit chk_addr;
    } vec_t;

    vec_t tbl [5];
    bit   ok;
    int   reps_r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {4'(i), 4'($urandom_range(0, 15))};

        tbl[0] = '{reps: 1, mode: 0, exp_words: 4,  exp_first: 3,  exp_done: 7,  exp_busy: 1, chk_addr: 1'b1};
        tbl[1] = '{reps: 3, mode: 1, exp_words: 12, exp_first: 3,  exp_done: -1, exp_busy: 1, chk_addr: 1'b0};
        tbl[2] = '{reps: 0, mode: 0, exp_words: 0,  exp_first: -1, exp_done: 1,  exp_busy: 0, chk_addr: 1'b0};
        tbl[3] = '{reps: 2, mode: 2, exp_words: 8,  exp_first: 3,  exp_done: -1, exp_busy: 1, chk_addr: 1'b0};
        tbl[4] = '{reps: 2, mode: 3, exp_words: 8,  exp_first: 3,  exp_done: -1, exp_busy: 1, chk_addr: 1'b0};

        #12;
        chk_eq("rst_busy",  longint'(busy), 0);
        chk_eq("rst_done",  longint'(done), 0);
        chk_eq("rst_valid", longint'(wgt_valid), 0);
        chk_eq("rst_addr",  longint'(wmem_addr), 0);
        chk_eq("rst_data",  longint'(wgt_data), 0);
        chk_eq("rst_tags",  longint'({wgt_sf_last, wgt_nf_last}), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) tick();

        for (int t = 0; t < 5; t++) begin
            do_run(tbl[t].reps, tbl[t].mode, 1'b0);
            chk_eq("tbl_words", word_cnt - words0, tbl[t].exp_words);
            chk_eq("tbl_first_valid_lat",
                   (first_valid_cyc < 0) ? -1 : first_valid_cyc - start_cyc, tbl[t].exp_first);
            chk_eq("tbl_busy_seen", busy_seen, tbl[t].exp_busy);
            if (tbl[t].exp_done >= 0) chk_eq("tbl_done_lat", done_cyc - start_cyc, tbl[t].exp_done);
            if (tbl[t].exp_words > 0) chk_eq("done_after_last_word", done_cyc - last_word_cyc, 1);
            if (tbl[t].chk_addr)
                for (int a = 0; a < 4; a++) chk_eq("addr_seq", addr_log[a], a);
            if (tbl[t].mode == 3) begin
                chk("addr_adv_in_stall", addr_chg <= 2, addr_chg, 2);
`ifdef MVAU_WSEQ_STALL_CNT_EN
                chk_eq("stall_cnt", longint'(stall_cnt), 10);
`endif
            end
        end

        // Reset asserted mid-run after the second word.
        build_exp(2);
        words0 = word_cnt; done0 = done_cnt;
        tick();
        start = 1'b1; num_reps = RBW'(2); wgt_ready = 1'b1;
        @(negedge aclk); #1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            start = 1'b0;
            @(negedge aclk); #1;
            if (word_cnt - words0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("reach_word2", longint'(ok), 1);
        aresetn = 1'b0;
        #1;
        chk_eq("arst_busy",  longint'(busy), 0);
        chk_eq("arst_done",  longint'(done), 0);
        chk_eq("arst_valid", longint'(wgt_valid), 0);
        chk_eq("arst_addr",  longint'(wmem_addr), 0);
        chk_eq("arst_data",  longint'(wgt_data), 0);
        chk_eq("arst_tags",  longint'({wgt_sf_last, wgt_nf_last}), 0);
`ifdef MVAU_WSEQ_STALL_CNT_EN
        chk_eq("arst_stall_cnt", longint'(stall_cnt), 0);
`endif
        exp_q.delete();
        repeat (3) tick();
        @(negedge aclk); #1;
        aresetn = 1'b1;
        repeat (4) begin
            tick();
            @(negedge aclk); #1;
            chk_eq("post_rst_idle_valid", longint'(wgt_valid), 0);
        end
        chk_eq("no_done_on_reset", done_cnt - done0, 0);
        chk_eq("post_rst_busy", longint'(busy), 0);
        do_run(1, 0, 1'b0);
        chk_eq("restart_addr0", addr_log[0], 0);
        chk_eq("restart_words", word_cnt - words0, 4);

        // A second start while busy must be ignored.
        do_run(2, 0, 1'b1);
        chk_eq("busy_start_ignored_words", word_cnt - words0, 2 * SF * NF);

        for (int k = 0; k < 6; k++) begin
            reps_r = int'($urandom_range(1, 5));
            do_run(reps_r, 2, 1'b0);
            chk_eq("rand_words", word_cnt - words0, reps_r * SF * NF);
            chk_eq("rand_first_valid_lat", first_valid_cyc - start_cyc, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
